// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM read master that checks the system-ID slave.
// Reads ID (addr 0) and timestamp (addr 1) and latches a pass/fail/timeout result.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1529049436,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE
  } state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        to_q, to_d;
  logic [31:0] idv_q, idv_d;
  logic [31:0] tsv_q, tsv_d;

  // Next-state and registered-output logic; the counter spans request plus wait.
  always_comb begin
    state_d = state_q;
    auto_d  = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    to_d    = to_q;
    idv_d   = idv_q;
    tsv_d   = tsv_q;
    cnt_inc = {1'b0, cnt_q} + 17'd1;
    unique case (state_q)
      IDLE, DONE: begin
        if (start || auto_q) begin
          state_d = ID_REQ;
          read_d  = 1'b1;
          addr_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          to_d    = 1'b0;
          idv_d   = '0;
          tsv_d   = '0;
        end
      end
      ID_REQ, TS_REQ: begin
        if (cnt_inc == TO_LIM) begin
          state_d = DONE;
          read_d  = 1'b0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc[15:0];
          if (!avm_waitrequest) begin
            read_d  = 1'b0;
            state_d = (state_q == ID_REQ) ? ID_WAIT : TS_WAIT;
          end
        end
      end
      ID_WAIT: begin
        if (avm_readdatavalid) begin
          idv_d   = avm_readdata;
          id_ok_d = (avm_readdata == EXPECTED_ID);
          state_d = TS_REQ;
          read_d  = 1'b1;
          addr_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_inc == TO_LIM) begin
          state_d = DONE;
          to_d    = 1'b1;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      TS_WAIT: begin
        if (avm_readdatavalid) begin
          tsv_d   = avm_readdata;
          ts_ok_d = (avm_readdata == EXPECTED_TIMESTAMP);
          pass_d  = id_ok_q && (avm_readdata == EXPECTED_TIMESTAMP);
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_inc == TO_LIM) begin
          state_d = DONE;
          to_d    = 1'b1;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any read immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      auto_q  <= AUTO_START;
      cnt_q   <= '0;
      addr_q  <= 1'b0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      to_q    <= 1'b0;
      idv_q   <= '0;
      tsv_q   <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      to_q    <= to_d;
      idv_q   <= idv_d;
      tsv_q   <= tsv_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = to_q;
  assign id_value    = idv_q;
  assign ts_value    = tsv_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// tb_sysid_probe_master: table-driven and randomized checks of sysid_probe_master.
// A scripted Avalon slave serves each read with set stall, latency and data.
module tb_sysid_probe_master;

  localparam int          TMO    = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1529049436;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;

  // slave script, indexed by word address
  int          cfg_s[2];
  int          cfg_l[2];
  bit          cfg_nr[2];
  logic [31:0] cfg_d[2];
  int          inj_req = 0;

  typedef struct {
    int          s0, l0, s1, l1;
    bit          nr0, nr1;
    logic [31:0] d0, d1;
    int          start_at;
    bit          late;
    int          cyc;
    bit          pass, idok, tsok, to;
    logic [31:0] idv, tsv;
  } vec_t;

  sysid_probe_master #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(TMO),
    .AUTO_START(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy),
    .done(done),
    .pass(pass),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // scripted slave: drives its outputs on the falling edge
  initial begin : slave
    int   pend;
    int   stall_left;
    bit   prev_rd;
    int   inj_seen;
    logic [31:0] pend_data;
    pend = 0; stall_left = 0; prev_rd = 0; inj_seen = 0; pend_data = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      if (!reset_n) begin
        pend = 0; stall_left = 0; prev_rd = 0;
        avm_waitrequest = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_data;
          end
        end
        if (inj_req != inj_seen) begin
          inj_seen = inj_req;
          avm_readdatavalid = 1'b1;
          avm_readdata = 32'hDEAD_BEEF;
        end
        if (avm_read) begin
          if (!prev_rd) stall_left = cfg_s[avm_address];
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            if (!cfg_nr[avm_address]) begin
              pend = cfg_l[avm_address];
              pend_data = cfg_d[avm_address];
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
        end
        prev_rd = avm_read;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: each transaction takes stall+1+latency cycles unless that
  // exceeds the timeout budget, in which case the run ends after TMO cycles.
  function automatic vec_t model(vec_t v);
    vec_t r;
    int   s[2];
    int   l[2];
    bit   nr[2];
    logic [31:0] d[2];
    int   tot;
    r = v;
    s[0] = v.s0; s[1] = v.s1;
    l[0] = v.l0; l[1] = v.l1;
    nr[0] = v.nr0; nr[1] = v.nr1;
    d[0] = v.d0; d[1] = v.d1;
    r.cyc = 1; r.to = 0; r.idok = 0; r.tsok = 0; r.idv = '0; r.tsv = '0;
    for (int t = 0; t < 2; t++) begin
      tot = nr[t] ? TMO + 1 : s[t] + 1 + l[t];
      if (tot > TMO) begin
        r.cyc += TMO;
        r.to = 1;
        break;
      end
      r.cyc += tot;
      if (t == 0) begin
        r.idv = d[0];
        r.idok = (d[0] == EXP_ID);
      end else begin
        r.tsv = d[1];
        r.tsok = (d[1] == EXP_TS);
      end
    end
    r.pass = !r.to && r.idok && r.tsok;
    return r;
  endfunction

  task automatic load_cfg(input vec_t v);
    cfg_s[0] = v.s0; cfg_s[1] = v.s1;
    cfg_l[0] = v.l0; cfg_l[1] = v.l1;
    cfg_nr[0] = v.nr0; cfg_nr[1] = v.nr1;
    cfg_d[0] = v.d0; cfg_d[1] = v.d1;
  endtask

  // Called at posedge+1; the next edge either samples start or is the
  // first edge after reset release.
  task automatic run_vec(input vec_t v, input bit drive_start,
                         input string nm);
    int   c;
    int   bad_busy;
    int   bad_stall;
    int   bad_idle;
    bit   prev_rd;
    logic prev_addr;
    load_cfg(v);
    start = drive_start;
    tick();
    start = 1'b0;
    c = 1;
    bad_busy = 0;
    bad_stall = 0;
    prev_rd = 1'b0;
    prev_addr = 1'b0;
    check({nm, " entry_done"}, {31'd0, done}, 32'd0);
    check({nm, " entry_busy"}, {31'd0, busy}, 32'd1);
    while (!done && c < 60) begin
      if (!busy) bad_busy++;
      start = (c == v.start_at);
      prev_rd = avm_read;
      prev_addr = avm_address;
      tick();
      start = 1'b0;
      c++;
      if (prev_rd && avm_waitrequest && !done)
        if (!avm_read || avm_address !== prev_addr) bad_stall++;
    end
    check({nm, " done_cycle"}, c, v.cyc);
    check({nm, " done"}, {31'd0, done}, 32'd1);
    check({nm, " busy_end"}, {31'd0, busy}, 32'd0);
    check({nm, " busy_during"}, bad_busy, 0);
    check({nm, " stall_stable"}, bad_stall, 0);
    check({nm, " flags"}, {28'd0, pass, id_ok, ts_ok, timeout},
          {28'd0, v.pass, v.idok, v.tsok, v.to});
    check({nm, " id_value"}, id_value, v.idv);
    check({nm, " ts_value"}, ts_value, v.tsv);
    if (v.late) begin
      inj_req++;
      tick();
      tick();
      check({nm, " late_idv"}, id_value, 32'd0);
    end
    bad_idle = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!done || busy || avm_read) bad_idle++;
    end
    check({nm, " hold_result"}, bad_idle, 0);
  endtask

  vec_t tbl[12];
  vec_t nom;
  vec_t rv;

  initial begin
    nom = '{s0:0, l0:1, s1:0, l1:1, nr0:0, nr1:0, d0:EXP_ID, d1:EXP_TS,
            start_at:0, late:0, cyc:5, pass:1, idok:1, tsok:1, to:0,
            idv:EXP_ID, tsv:EXP_TS};
    tbl[0] = nom;
    tbl[1] = nom;
    tbl[1].d1 = EXP_TS + 1; tbl[1].pass = 0; tbl[1].tsok = 0;
    tbl[1].tsv = EXP_TS + 1;
    tbl[2] = nom;
    tbl[2].d0 = 32'd5; tbl[2].pass = 0; tbl[2].idok = 0; tbl[2].idv = 32'd5;
    tbl[3] = nom;
    tbl[3].s0 = 3; tbl[3].l0 = 2; tbl[3].s1 = 3; tbl[3].l1 = 2; tbl[3].cyc = 13;
    tbl[4] = nom;
    tbl[4].s0 = 2; tbl[4].l0 = 2; tbl[4].s1 = 2; tbl[4].l1 = 2; tbl[4].cyc = 11;
    tbl[5] = nom;
    tbl[5].nr0 = 1; tbl[5].late = 1; tbl[5].cyc = 9; tbl[5].pass = 0;
    tbl[5].idok = 0; tbl[5].tsok = 0; tbl[5].to = 1;
    tbl[5].idv = 0; tbl[5].tsv = 0;
    tbl[6] = nom;
    tbl[6].s0 = 3; tbl[6].l0 = 4; tbl[6].cyc = 11;
    tbl[7] = nom;
    tbl[7].s0 = 4; tbl[7].l0 = 4; tbl[7].cyc = 9; tbl[7].pass = 0;
    tbl[7].idok = 0; tbl[7].tsok = 0; tbl[7].to = 1;
    tbl[7].idv = 0; tbl[7].tsv = 0;
    tbl[8] = nom;
    tbl[8].nr1 = 1; tbl[8].cyc = 11; tbl[8].pass = 0; tbl[8].tsok = 0;
    tbl[8].to = 1; tbl[8].tsv = 0;
    tbl[9] = nom;
    tbl[9].start_at = 2;
    tbl[10] = nom;
    tbl[10].start_at = 4;
    tbl[11] = tbl[8];
    tbl[11].nr1 = 0; tbl[11].s1 = 20;

    reset_n = 1'b0;
    start = 1'b0;
    load_cfg(nom);
    tick();
    tick();
    check("reset_flags",
          {24'd0, avm_address, avm_read, busy, done, pass, id_ok, ts_ok,
           timeout}, 32'd0);
    check("reset_idv", id_value, 32'd0);
    check("reset_tsv", ts_value, 32'd0);

    reset_n = 1'b1;
    run_vec(nom, 1'b0, "auto_start");

    for (int i = 0; i < 12; i++)
      run_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

    load_cfg(nom);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midreset_flags",
          {24'd0, avm_address, avm_read, busy, done, pass, id_ok, ts_ok,
           timeout}, 32'd0);
    check("midreset_idv", id_value, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    run_vec(nom, 1'b0, "rerun_after_reset");

    for (int i = 0; i < 25; i++) begin
      rv = nom;
      rv.s0 = $urandom_range(0, 3);
      rv.l0 = $urandom_range(1, 4);
      rv.s1 = $urandom_range(0, 3);
      rv.l1 = $urandom_range(1, 4);
      rv.nr0 = ($urandom_range(0, 7) == 0);
      rv.nr1 = ($urandom_range(0, 7) == 0);
      rv.d0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
      rv.d1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
      rv.start_at = $urandom_range(0, 6);
      rv = model(rv);
      run_vec(rv, 1'b1, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
